main_fsm: RTL and testbench

Main control state machine for the multicycle RV32I core. It sequences the shared ALU, memory, instruction register, PC and register file across cycles. It decodes the 7-bit opcode into per-cycle control strobes and drives the 2-bit `alu_op` consumed by the ALU decoder. It supports lw, sw, R-type, I-type ALU, jal and beq.

---
 rtl/main_fsm.sv | 129 ++++++++++++
 tb/tb_main_fsm.sv | 127 ++++++++++++
 2 files changed

// File: rtl/main_fsm.sv
// main_fsm: multicycle RV32I control FSM sequencing ALU, memory, IR, PC and register file.
// Moore strobes decoded from state; pc_write and illegal_op add zero/op terms.
module main_fsm (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] op,
    input  logic       zero,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       illegal_op,
    output logic [3:0] state
);
    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADR   = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXEC_R    = 4'd6,
        ALU_WB    = 4'd7,
        EXEC_I    = 4'd8,
        JAL       = 4'd9,
        BEQ       = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    state_t state_q, state_d;
    logic   pc_update, branch;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= FETCH;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d    = FETCH;
        pc_update  = 1'b0;
        branch     = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        illegal_op = 1'b0;
        case (state_q)
            FETCH: begin
                ir_write   = 1'b1;
                pc_update  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                state_d    = DECODE;
            end
            DECODE: begin
                // old PC + imm lands in ALUOut as the branch target
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_d = MEM_ADR;
                    OP_R:         state_d = EXEC_R;
                    OP_I:         state_d = EXEC_I;
                    OP_JAL:       state_d = JAL;
                    OP_BEQ:       state_d = BEQ;
                    default:      illegal_op = 1'b1;
                endcase
            end
            MEM_ADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = (op == OP_LW) ? MEM_READ : (op == OP_SW) ? MEM_WRITE : FETCH;
            end
            MEM_READ: begin
                adr_src = 1'b1;
                state_d = MEM_WB;
            end
            MEM_WB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
            end
            MEM_WRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            EXEC_R: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
                state_d   = ALU_WB;
            end
            ALU_WB: reg_write = 1'b1;
            EXEC_I: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
                state_d   = ALU_WB;
            end
            JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_update = 1'b1;
                state_d   = ALU_WB;
            end
            BEQ: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                branch    = 1'b1;
            end
            default: ;
        endcase
    end

    assign pc_write = pc_update | (branch & zero);
    assign state    = state_q;
endmodule

// File: tb/tb_main_fsm.sv
// tb_main_fsm: table-driven check of main_fsm state sequences and per-state controls.
// Output bundle order: pc_write, adr_src, mem_write, ir_write, reg_write, result_src, alu_src_a, alu_src_b, alu_op, illegal_op.
module tb_main_fsm;
    logic       clk = 1'b0;
    logic       reset_n;
    logic [6:0] op;
    logic       zero;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_op;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
    logic [3:0] state;
    logic [13:0] outs;

    main_fsm dut (
        .clk(clk), .reset_n(reset_n), .op(op), .zero(zero),
        .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
        .ir_write(ir_write), .reg_write(reg_write), .result_src(result_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .illegal_op(illegal_op), .state(state)
    );

    always #5 clk = ~clk;
    assign outs = {pc_write, adr_src, mem_write, ir_write, reg_write,
                   result_src, alu_src_a, alu_src_b, alu_op, illegal_op};

    localparam logic [6:0] L = 7'b0000011, S = 7'b0100011, R = 7'b0110011;
    localparam logic [6:0] I = 7'b0010011, J = 7'b1101111, B = 7'b1100011, X = 7'b1111111;

    localparam logic [13:0] O_F    = 14'b1_0_0_1_0_10_00_10_00_0;
    localparam logic [13:0] O_D    = 14'b0_0_0_0_0_00_01_01_00_0;
    localparam logic [13:0] O_DX   = 14'b0_0_0_0_0_00_01_01_00_1;
    localparam logic [13:0] O_MA   = 14'b0_0_0_0_0_00_10_01_00_0;
    localparam logic [13:0] O_MR   = 14'b0_1_0_0_0_00_00_00_00_0;
    localparam logic [13:0] O_MWB  = 14'b0_0_0_0_1_01_00_00_00_0;
    localparam logic [13:0] O_MW   = 14'b0_1_1_0_0_00_00_00_00_0;
    localparam logic [13:0] O_ER   = 14'b0_0_0_0_0_00_10_00_10_0;
    localparam logic [13:0] O_AWB  = 14'b0_0_0_0_1_00_00_00_00_0;
    localparam logic [13:0] O_EI   = 14'b0_0_0_0_0_00_10_01_10_0;
    localparam logic [13:0] O_JAL  = 14'b1_0_0_0_0_00_01_10_00_0;
    localparam logic [13:0] O_BT   = 14'b1_0_0_0_0_00_10_00_01_0;
    localparam logic [13:0] O_BN   = 14'b0_0_0_0_0_00_10_00_01_0;

    typedef struct {
        logic [6:0]  op;
        logic        zero;
        logic [3:0]  st;
        logic [13:0] outs;
    } vec_t;

    vec_t vecs[$];
    int errors = 0;
    int checks = 0;

    task automatic add(input logic [6:0] o, input logic z, input logic [3:0] s, input logic [13:0] e);
        vecs.push_back('{op: o, zero: z, st: s, outs: e});
    endtask

    task automatic chk(input string name, input logic [13:0] act, input logic [13:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        // lw
        add(L,0,0,O_F);  add(L,0,1,O_D);  add(L,0,2,O_MA); add(L,0,3,O_MR); add(L,0,4,O_MWB);
        // sw
        add(S,1,0,O_F);  add(S,0,1,O_D);  add(S,0,2,O_MA); add(S,0,5,O_MW);
        // R-type
        add(R,0,0,O_F);  add(R,0,1,O_D);  add(R,1,6,O_ER); add(R,0,7,O_AWB);
        // beq taken, then not taken
        add(B,0,0,O_F);  add(B,0,1,O_D);  add(B,1,10,O_BT);
        add(B,1,0,O_F);  add(B,1,1,O_D);  add(B,0,10,O_BN);
        // jal
        add(J,0,0,O_F);  add(J,0,1,O_D);  add(J,0,9,O_JAL); add(J,1,7,O_AWB);
        // I-type
        add(I,0,0,O_F);  add(I,0,1,O_D);  add(I,0,8,O_EI); add(I,0,7,O_AWB);
        // illegal
        add(X,0,0,O_F);  add(X,1,1,O_DX);
        // op neither lw nor sw in MemAdr returns to Fetch
        add(L,0,0,O_F);  add(L,0,1,O_D);  add(R,0,2,O_MA);
        add(L,0,0,O_F);

        reset_n = 1'b0;
        op = X;
        zero = 1'b0;
        #3;
        chk("reset_state", {10'd0, state}, 14'd0);
        chk("reset_outs", outs, O_F);
        #5 reset_n = 1'b1;

        foreach (vecs[k]) begin
            @(negedge clk);
            op = vecs[k].op;
            zero = vecs[k].zero;
            #1;
            chk($sformatf("vec%0d_state", k), {10'd0, state}, {10'd0, vecs[k].st});
            chk($sformatf("vec%0d_outs", k), outs, vecs[k].outs);
        end

        // reset asserted mid-MemWrite aborts the store
        op = S;
        zero = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("sw_memwrite_state", {10'd0, state}, 14'd5);
        chk("sw_memwrite_strobe", {13'd0, mem_write}, 14'd1);
        reset_n = 1'b0;
        #1;
        chk("abort_state", {10'd0, state}, 14'd0);
        chk("abort_outs", outs, O_F);
        @(posedge clk);
        #1;
        chk("held_state", {10'd0, state}, 14'd0);
        chk("held_mem_write", {13'd0, mem_write}, 14'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset_state", {10'd0, state}, 14'd1);
        chk("post_reset_outs", outs, O_D);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
